// File: rtl/ysyx_22041207_multiplier.sv
// Sequential 64x64 multiplier returning the low 64 bits of the product.
// Default build: radix-4 Booth engine (33 cycles). Define YSYX_MUL_FAST_EN for a single-cycle multiply.
module ysyx_22041207_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_valid,
    input  logic        flush,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        mul_ready,
    output logic        out_valid,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] mcand;
    logic [66:0] mreg;
    logic        accept;
    logic        last_iter;

    assign accept = (state != BUSY) && mul_valid && !flush;

`ifndef YSYX_MUL_FAST_EN
    logic [63:0] acc;
    logic [63:0] acc_nxt;
    logic [5:0]  cnt;

    // One Booth digit d in {0,+-1,+-2}, scaled by 4^idx, all mod 2^64.
    // Shifts of 64 and above fall off the top and contribute nothing.
    function automatic logic [63:0] booth_term(input logic [2:0]  bits,
                                               input logic [63:0] a,
                                               input logic [5:0]  idx);
        logic [63:0]        mag;
        logic               neg;
        logic signed [63:0] term;
        logic [6:0]         shamt;
        mag = 64'd0;
        neg = 1'b0;
        case (bits)
            3'b001, 3'b010: mag = a;
            3'b011:         mag = a << 1;
            3'b100:         begin mag = a << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a;      neg = 1'b1; end
            default:        mag = 64'd0;
        endcase
        term  = neg ? -$signed(mag) : $signed(mag);
        shamt = {idx, 1'b0};
        return $unsigned(term) << shamt;
    endfunction

    assign acc_nxt   = acc + booth_term(mreg[2:0], mcand, cnt);
    assign last_iter = (cnt == 6'd32);
`else
    assign last_iter = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        mul_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                mul_ready = 1'b1;
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                mul_ready = 1'b1;
                out_valid = 1'b1;
                state_nxt = accept ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // flush wins over everything, including a simultaneous request
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= 64'd0;
            mreg   <= 67'd0;
            result <= 64'd0;
`ifndef YSYX_MUL_FAST_EN
            acc    <= 64'd0;
            cnt    <= 6'd0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand <= multiplicand;
                mreg  <= {2'b00, multiplier, 1'b0};
`ifndef YSYX_MUL_FAST_EN
                acc   <= 64'd0;
                cnt   <= 6'd0;
`endif
            end else if (state == BUSY && !flush) begin
`ifndef YSYX_MUL_FAST_EN
                acc  <= acc_nxt;
                mreg <= mreg >> 2;
                cnt  <= cnt + 6'd1;
                if (last_iter) result <= acc_nxt;
`else
                result <= mcand * mreg[64:1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_multiplier.sv
// Directed + random bench for ysyx_22041207_multiplier with a transaction-level reference model.
module tb_ysyx_22041207_multiplier;

`ifdef YSYX_MUL_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mul_valid = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    ysyx_22041207_multiplier dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .multiplicand (a),
        .multiplier   (b),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a request occupies the unit for LAT cycles, then one strobe.
    logic        m_busy = 1'b0;
    logic        m_strobe = 1'b0;
    logic [63:0] m_res = 64'd0;
    logic [63:0] m_prod = 64'd0;
    int          m_rem = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_strobe = 1'b0; m_res = 64'd0; m_rem = 0;
        end else if (flush) begin
            m_busy = 1'b0; m_strobe = 1'b0;
        end else if (!m_busy && mul_valid) begin
            m_busy = 1'b1; m_rem = LAT; m_prod = a * b; m_strobe = 1'b0;
        end else if (m_busy) begin
            m_rem--;
            m_strobe = 1'b0;
            if (m_rem == 0) begin
                m_busy = 1'b0; m_strobe = 1'b1; m_res = m_prod;
            end
        end else begin
            m_strobe = 1'b0;
        end
    end

    always @(negedge clk) begin
        check64("model_ready", {63'd0, mul_ready}, {63'd0, !m_busy});
        check64("model_out_valid", {63'd0, out_valid}, {63'd0, m_strobe});
        check64("model_result", result, m_res);
    end

    // Called one cycle-edge after acceptance; counts edges until the strobe.
    task automatic wait_strobe(input string name, input logic [63:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 45) begin
            @(posedge clk) #1;
            n++;
        end
        check64({name, "_strobe_seen"}, {63'd0, out_valid}, 64'd1);
        check64({name, "_latency"}, 64'(n), 64'(LAT));
        check64({name, "_result"}, result, exp);
    endtask

    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic [63:0] exp, input string name);
        @(posedge clk) #1;
        a = ta; b = tb_v; mul_valid = 1'b1;
        @(posedge clk) #1;
        mul_valid = 1'b0;
        if (LAT > 1) check64({name, "_busy_ready"}, {63'd0, mul_ready}, 64'd0);
        wait_strobe(name, exp);
    endtask

    task automatic count_strobes(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk) #1;
            if (out_valid) seen++;
        end
    endtask

    initial begin
        logic [63:0] x, y, p, saved;
        int seen;

        #2;
        check64("reset_ready", {63'd0, mul_ready}, 64'd1);
        check64("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check64("reset_result", result, 64'd0);
        @(posedge clk) #1;
        rst = 1'b0;

        do_op(64'd3, 64'd5, 64'h000000000000000F, "basic");
        do_op(64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, "wrap_neg1x2");
        do_op(64'h8000000000000000, 64'h8000000000000000, 64'd0, "wrap_msb");
        do_op(64'hFFFFFFFFFFFFFFF9, 64'd6, 64'hFFFFFFFFFFFFFFD6, "signed_m7x6");
        do_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd1, "neg1_sq");

        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            p = x * y;
            do_op(x, y, p, "random");
        end

        // Flush mid-operation
        saved = result;
        @(posedge clk) #1;
        a = 64'd9; b = 64'd9; mul_valid = 1'b1;
        @(posedge clk) #1;
        mul_valid = 1'b0;
        repeat (9) @(posedge clk) #1;
        flush = 1'b1;
        @(posedge clk) #1;
        flush = 1'b0;
        check64("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check64("flush_ready", {63'd0, mul_ready}, 64'd1);
        check64("flush_result_kept", result, saved);
        count_strobes(45, seen);
        check64("flush_no_strobe", 64'(seen), 64'd0);
        do_op(64'd7, 64'd6, 64'd42, "after_flush");

        // Busy ignore with mul_valid held, then back-to-back request in DONE
        @(posedge clk) #1;
        a = 64'd2; b = 64'd3; mul_valid = 1'b1;
        @(posedge clk) #1;
        a = 64'd100; b = 64'd100;
        wait_strobe("busy_ignore", 64'd6);
        a = 64'd4; b = 64'd5;
        @(posedge clk) #1;
        mul_valid = 1'b0;
        wait_strobe("back_to_back", 64'd20);
        count_strobes(40, seen);
        check64("b2b_single_strobe", 64'(seen), 64'd0);

        // Reset mid-operation
        @(posedge clk) #1;
        a = 64'd11; b = 64'd13; mul_valid = 1'b1;
        @(posedge clk) #1;
        mul_valid = 1'b0;
        repeat (14) @(posedge clk) #1;
        rst = 1'b1;
        #1;
        check64("midrst_ready", {63'd0, mul_ready}, 64'd1);
        check64("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("midrst_result", result, 64'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        count_strobes(45, seen);
        check64("midrst_no_strobe", 64'(seen), 64'd0);

        do_op(64'd12345, 64'd1000, 64'd12345000, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_multiplier.md
# ysyx_22041207_multiplier

Sequential 64×64 integer multiplier returning the low 64 bits of the product. It sits inside the execute-stage ALU and serves the RV64 `mul` operation. The ALU pulses a request and stalls until the result strobe. The low 64 bits are identical for signed and unsigned operands, so the block has no signedness input. The default build is a radix-4 Booth shift-add engine: 33 iterations, one Booth digit per cycle.

## Interface
Parameters: none.

Ports (positional order fixed: clk, rst, mul_valid, flush, multiplicand, multiplier, mul_ready, out_valid, result):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mul_valid  in  1  request strobe; accepted only when mul_ready=1.
- flush  in  1  synchronous pipeline flush; aborts any operation.
- multiplicand  in  64  operand A, latched on acceptance.
- multiplier  in  64  operand B, latched on acceptance.
- mul_ready  out  1  block can accept a request this cycle.
- out_valid  out  1  one-cycle strobe: result holds a new product.
- result  out  64  (A×B) mod 2^64; holds its last value until the next completion.

## Operation
- States:
  - IDLE: mul_ready=1, out_valid=0.
  - BUSY: iterating; mul_ready=0.
  - DONE: one cycle; out_valid=1, mul_ready=1.
- Acceptance (IDLE or DONE, mul_valid=1, flush=0):
  - Latch A into a 64-bit multiplicand register.
  - Latch B, zero-extended to 66 bits, with an appended 0 below bit 0 (67-bit shift register).
  - Clear the 64-bit accumulator and the iteration counter. Go to BUSY.
- Each BUSY cycle:
  - Decode the lowest 3 bits of the shift register as a Booth digit d ∈ {0, ±1, ±2}.
  - Add d·A·4^i to the accumulator, mod 2^64 (i = counter).
  - Shift the register right by 2. Increment the counter.
- After iteration 32 (the 33rd digit): write the accumulator to result and go to DONE.
- DONE:
  - If mul_valid=1, accept the new request and go to BUSY.
  - Otherwise go to IDLE.
- mul_valid in BUSY is ignored and not queued.
- flush=1 in any state:
  - Next state is IDLE; out_valid=0 next cycle.
  - The in-flight product is discarded; result is not updated.
  - flush overrides a simultaneous mul_valid.
- All additions wrap mod 2^64; no overflow flag.

## Timing
- Reset values: state IDLE, mul_ready=1, out_valid=0, result=0, counter=0, operand registers=0.
- Request accepted at edge E0. Iterations occur at edges E1..E33.
- out_valid is high for exactly one cycle, E33→E34. Latency is 33 cycles from acceptance to strobe.
- mul_ready falls after E0 and rises again after E33, i.e. during the DONE cycle.
- Back-to-back: a request accepted at the DONE edge starts its own 33-cycle operation with no gap cycle.
- Operand inputs may change freely after E0.
- Reset asserted mid-operation returns to IDLE immediately; no out_valid follows.

## Configuration
- YSYX_MUL_FAST_EN defined:
  - The product is computed by a single combinational multiply of the latched operands.
  - BUSY lasts one cycle, so out_valid rises after edge E1 (latency 1).
  - Handshake, flush and reset rules are unchanged.
- Undefined (default): the radix-4 Booth engine, latency 33.

## Test plan
- Basic: A=3, B=5 → out_valid exactly 33 cycles after acceptance; result=0x000000000000000F; mul_ready=0 during BUSY.
- Wrap: A=0xFFFFFFFFFFFFFFFF, B=2 → 0xFFFFFFFFFFFFFFFE. A=0x8000000000000000, B=0x8000000000000000 → 0.
- Signed equivalence: A=−7 (0xFFFFFFFFFFFFFFF9), B=6 → 0xFFFFFFFFFFFFFFD6. Then 1000 random pairs checked against the low 64 bits of A×B.
- Flush: start A=9, B=9; assert flush 10 cycles in → no out_valid, mul_ready=1 next cycle, result unchanged. Then 7×6 → 42.
- Back-to-back and busy ignore:
  - Issue 2×3, hold mul_valid high through BUSY with other operands → only one strobe, result=6.
  - Re-request in the DONE cycle with 4×5 → strobe 33 cycles later, result=20.
- Reset mid-op: assert rst at cycle 15 of A=11, B=13 → all outputs at reset values immediately; no strobe afterwards.
